// File: rtl/niosii_timer_host_pkg.sv
// Shared definitions for the interval-timer host: bus widths, timer register
// map, control-register bit positions, FSM state encoding and the transfer
// request struct handed from the sequencer to the single-transfer engine.
package niosii_timer_host_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] REG_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_CONTROL  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_PERIOD_L = 3'd2;
  localparam logic [ADDR_W-1:0] REG_PERIOD_H = 3'd3;
  localparam logic [ADDR_W-1:0] REG_SNAP_L   = 3'd4;
  localparam logic [ADDR_W-1:0] REG_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [DATA_W-1:0] CTRL_STOP_WORD = DATA_W'(1) << CTRL_STOP;

  typedef enum logic [3:0] {
    ST_IDLE, ST_STOP, ST_PER_L, ST_PER_H, ST_CLR0, ST_START,
    ST_WAIT, ST_SNAP_W, ST_RD_L, ST_RD_H, ST_CLR, ST_HALT
  } state_t;

  typedef struct packed {
    logic              vld;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_req_t;

  // Control word that starts the timer with interrupts enabled.
  function automatic logic [DATA_W-1:0] ctrl_start_word(input logic cont);
    ctrl_start_word             = '0;
    ctrl_start_word[CTRL_ITO]   = 1'b1;
    ctrl_start_word[CTRL_CONT]  = cont;
    ctrl_start_word[CTRL_START] = 1'b1;
  endfunction

  function automatic xfer_req_t mk_req(input logic rd, input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] wdata);
    mk_req = '{vld: 1'b1, rd: rd, addr: addr, wdata: wdata};
  endfunction
endpackage

// File: rtl/niosii_timer_host_if.sv
// Avalon-MM bus between the timer host (master) and the interval timer (slave).
// master: drives address/chipselect/write_n/read_n/writedata, sees readdata/waitrequest.
// slave : the opposite directions.
interface niosii_timer_host_if;
  import niosii_timer_host_pkg::*;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic              read_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (output address, chipselect, write_n, read_n, writedata,
                  input  readdata, waitrequest);
  modport slave  (input  address, chipselect, write_n, read_n, writedata,
                  output readdata, waitrequest);
endinterface

// File: rtl/niosii_timer_host_xfer.sv
// One-transfer Avalon-MM engine. Issues the request presented on req, holds the
// registered bus outputs stable under waitrequest, and reports completion.
//   clk, reset_n : clock, async active-low reset
//   req          : request (vld/rd/addr/wdata); must stay asserted until done
//   done         : write -> acceptance cycle; read -> cycle after acceptance
//   rdata        : read data, valid while done is high for a read
//   bus          : Avalon-MM master side
module niosii_timer_host_xfer
  import niosii_timer_host_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  xfer_req_t         req,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  niosii_timer_host_if.master bus
);
  logic accept;
  logic rd_pend;  // read accepted last cycle; readdata is valid now

  assign accept = bus.chipselect & ~bus.waitrequest;
  assign done   = (accept & bus.read_n) | rd_pend;
  assign rdata  = bus.readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.chipselect <= 1'b0;
      bus.write_n    <= 1'b1;
      bus.read_n     <= 1'b1;
      bus.address    <= '0;
      bus.writedata  <= '0;
      rd_pend        <= 1'b0;
    end else begin
      rd_pend <= accept & ~bus.read_n;
      if (accept) begin
        bus.chipselect <= 1'b0;
        bus.write_n    <= 1'b1;
        bus.read_n     <= 1'b1;
      end else if (req.vld && !bus.chipselect && !rd_pend) begin
        // Idle gap after every transfer guarantees the requester has moved on
        // before a new request is taken, so nothing is ever issued twice.
        bus.chipselect <= 1'b1;
        bus.address    <= req.addr;
        bus.writedata  <= req.wdata;
        bus.write_n    <= req.rd;
        bus.read_n     <= ~req.rd;
      end
    end
  end
endmodule

// File: rtl/niosii_timer_host.sv
// Avalon-MM master that runs the interval timer as a periodic tick source:
// programs period/control, services each irq (optional counter snapshot),
// clears status and counts serviced timeouts.
//   clk, reset_n : clock, async active-low reset
//   enable       : level run request
//   period       : timer period, sampled when leaving IDLE
//   bus          : Avalon-MM master to the timer
//   irq          : timer interrupt (level)
//   tick         : one-cycle pulse per serviced timeout
//   tick_count   : serviced timeouts since start (wraps)
//   snapshot     : last captured counter value
//   busy         : state is not IDLE
module niosii_timer_host
  import niosii_timer_host_pkg::*;
#(
  parameter int CONTINUOUS    = 1,
  parameter int READ_SNAPSHOT = 1,
  parameter int TICK_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [31:0]       period,
  niosii_timer_host_if.master bus,
  input  logic              irq,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot,
  output logic              busy
);
  localparam logic CONT = (CONTINUOUS != 0);

  state_t            state;
  logic [31:0]       period_q;
  logic              irq_mask;  // status clear still propagating in the timer
  logic              hold;      // one-shot finished; wait for enable to drop
  xfer_req_t         req;
  logic              done;
  logic [DATA_W-1:0] rdata;

  niosii_timer_host_xfer u_xfer (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done), .rdata(rdata), .bus(bus)
  );

  always_comb begin
    req = '0;
    case (state)
      ST_STOP:   req = mk_req(1'b0, REG_CONTROL,  CTRL_STOP_WORD);
      ST_PER_L:  req = mk_req(1'b0, REG_PERIOD_L, period_q[15:0]);
      ST_PER_H:  req = mk_req(1'b0, REG_PERIOD_H, period_q[31:16]);
      ST_CLR0:   req = mk_req(1'b0, REG_STATUS,   '0);
      ST_START:  req = mk_req(1'b0, REG_CONTROL,  ctrl_start_word(CONT));
      ST_SNAP_W: req = mk_req(1'b0, REG_SNAP_L,   '0);
      ST_RD_L:   req = mk_req(1'b1, REG_SNAP_L,   '0);
      ST_RD_H:   req = mk_req(1'b1, REG_SNAP_H,   '0);
      ST_CLR:    req = mk_req(1'b0, REG_STATUS,   '0);
      ST_HALT:   req = mk_req(1'b0, REG_CONTROL,  CTRL_STOP_WORD);
      default:   req = '0;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      period_q   <= '0;
      irq_mask   <= 1'b0;
      hold       <= 1'b0;
      tick       <= 1'b0;
      tick_count <= '0;
      snapshot   <= '0;
    end else begin
      tick     <= 1'b0;
      irq_mask <= 1'b0;
      if (!enable) hold <= 1'b0;
      case (state)
        ST_IDLE: if (enable && !hold) begin
          period_q   <= period;
          tick_count <= '0;
          state      <= ST_STOP;
        end
        ST_STOP:   if (done) state <= ST_PER_L;
        ST_PER_L:  if (done) state <= ST_PER_H;
        ST_PER_H:  if (done) state <= ST_CLR0;
        ST_CLR0:   if (done) state <= ST_START;
        ST_START:  if (done) state <= ST_WAIT;
        ST_WAIT: begin
          if (irq && !irq_mask) state <= (READ_SNAPSHOT != 0) ? ST_SNAP_W : ST_CLR;
          else if (!enable)     state <= ST_HALT;
        end
        ST_SNAP_W: if (done) state <= ST_RD_L;
        ST_RD_L: if (done) begin
          snapshot[15:0] <= rdata;
          state          <= ST_RD_H;
        end
        ST_RD_H: if (done) begin
          snapshot[31:16] <= rdata;
          state           <= ST_CLR;
        end
        ST_CLR: if (done) begin
          tick       <= 1'b1;
          tick_count <= tick_count + TICK_W'(1);
          if (!CONT) begin
            hold  <= 1'b1;
            state <= ST_HALT;
          end else if (!enable) begin
            state <= ST_HALT;
          end else begin
            irq_mask <= 1'b1;
            state    <= ST_WAIT;
          end
        end
        ST_HALT:   if (done) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/niosii_timer_host.md
Name: niosII_timer_host

Overview:
- Avalon-MM master that drives the system interval-timer slave from the other end of its register interface.
- Programs period and control, waits for the timer irq, snapshots the counter, clears status, and counts elapsed ticks.
- Sits beside the timer in the niosII system so hardware logic can run a periodic tick without CPU involvement.

Parameters:
- CONTINUOUS, 1: value written to control bit 1; 0 gives one-shot mode, with a stop after the first tick.
- READ_SNAPSHOT, 1: 1 runs the snapshot write/read sequence on each tick; 0 skips straight to the status clear.
- TICK_W, 16: width of tick_count.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 requests running, 0 requests stopped
- period  in  32  timer period value, sampled on the IDLE->STOP transition
- address  out  3  timer register index (0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h)
- chipselect  out  1  transfer active
- write_n  out  1  active-low write
- read_n  out  1  active-low read
- writedata  out  16  write data
- readdata  in  16  timer read data, valid exactly 1 cycle after an accepted read
- waitrequest  in  1  slave stall; the transfer is accepted in the cycle chipselect=1 and waitrequest=0
- irq  in  1  timer interrupt, level
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts since start; wraps
- snapshot  out  32  last captured counter value
- busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Reset values: chipselect=0, write_n=1, read_n=1, address=0, writedata=0, tick=0, tick_count=0, snapshot=0, busy=0. The FSM resets to IDLE.
- Bus outputs are registered and held stable while waitrequest=1. At most one transfer is in flight. In non-transfer states chipselect=0.
- FSM states and transitions:
  - IDLE: when enable=1, latch period into period_q, clear tick_count, go to STOP.
  - STOP: write addr1 = 0x0008 (stop). Go to PER_L.
  - PER_L: write addr2 = period_q[15:0]. Go to PER_H.
  - PER_H: write addr3 = period_q[31:16]. Go to CLR0.
  - CLR0: write addr0 = 0x0000 to clear any stale timeout. Go to START.
  - START: write addr1 = {12'b0, 1'b0, 1'b1, CONTINUOUS, 1'b1}, i.e. 0x0007 or 0x0005. Go to WAIT.
  - WAIT: irq=1 goes to SNAP_W if READ_SNAPSHOT else CLR. irq=0 and enable=0 goes to HALT. irq takes priority over enable=0.
  - SNAP_W: write addr4 = 0x0000 to latch the counter. Go to RD_L.
  - RD_L: read addr4. One cycle after acceptance, capture readdata into snapshot[15:0]. Go to RD_H.
  - RD_H: read addr5, capture into snapshot[31:16]. Go to CLR.
  - CLR: write addr0 = 0x0000. On acceptance pulse tick and increment tick_count (wraps at 2^TICK_W-1 -> 0). If CONTINUOUS=0 go to HALT. Else if enable=0 go to HALT. Else go to WAIT.
  - HALT: write addr1 = 0x0008. Go to IDLE.
- Each write state advances on the acceptance cycle.
- Each read state issues in cycle A, the acceptance cycle. It holds chipselect=0 in A+1, samples readdata in A+1, then advances.
- enable dropping mid-sequence (STOP..START, SNAP_W..CLR): finish the sequence, then go to HALT from WAIT or CLR. No transfer is ever abandoned.
- A period change while running is ignored until the next IDLE exit.
- irq still high on re-entry to WAIT after CLR: the 1-cycle status-write latency means the bench must not see double counting. WAIT ignores irq for 1 cycle after CLR accepts; an irq that is still high after that cycle counts as a new timeout.
- Asynchronous reset mid-transfer: outputs go to reset values immediately, with no completion.

Decomposition:
- Shared package niosII_timer_pkg holds the register-address constants (STATUS=0, CONTROL=1, PERIOD_L=2, PERIOD_H=3, SNAP_L=4, SNAP_H=5), the control bit positions (ITO=0, CONT=1, START=2, STOP=3) and the FSM state enum.
- One natural sub-module: niosII_avm_single_xfer, a one-transfer Avalon-MM engine. It takes a request (addr, wdata, is_read), drives the bus and handles waitrequest, and returns done plus rdata.

Test Plan:
- Bring-up: period=0x00000063, enable=1, waitrequest=0 -> writes in order addr1=0x0008, addr2=0x0063, addr3=0x0000, addr0=0x0000, addr1=0x0007; busy=1.
- Tick service: after start, pulse irq high; slave returns 0x0012 on the snap_l read and 0x0000 on snap_h -> writes addr4, reads addr4 then addr5, writes addr0. snapshot=0x00000012, tick pulses once, tick_count=1.
- Waitrequest: hold waitrequest=1 for 3 cycles on the addr2 write -> address, writedata and chipselect stay stable for all 4 cycles, then the next transfer starts.
- Disable: enable=0 while in WAIT -> single write addr1=0x0008, then IDLE, busy=0. Re-enable -> tick_count restarts at 0.
- One-shot: CONTINUOUS=0 -> start write is 0x0005; after the first irq service, HALT writes 0x0008 and the FSM reaches IDLE even with enable=1 (no restart until enable toggles).
- Async reset asserted during the RD_L stall -> chipselect=0, tick_count=0 and the FSM is in IDLE within the same cycle.
